// File: rtl/vga_pkg.sv
// Shared VGA 640x480 timing defaults, derived totals/sync bounds, and the coordinate type.
package vga_pkg;

    localparam int H_ACTIVE_D = 640;
    localparam int H_FP_D     = 16;
    localparam int H_SYNC_D   = 96;
    localparam int H_BP_D     = 48;
    localparam int V_ACTIVE_D = 480;
    localparam int V_FP_D     = 10;
    localparam int V_SYNC_D   = 2;
    localparam int V_BP_D     = 33;

    localparam int H_TOTAL_D  = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;
    localparam int V_TOTAL_D  = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;
    localparam int HS_START_D = H_ACTIVE_D + H_FP_D;
    localparam int HS_END_D   = H_ACTIVE_D + H_FP_D + H_SYNC_D - 1;
    localparam int VS_START_D = V_ACTIVE_D + V_FP_D;
    localparam int VS_END_D   = V_ACTIVE_D + V_FP_D + V_SYNC_D - 1;

    typedef logic [9:0] coord_t;

endpackage

// File: rtl/edge_rise.sv
// Registered rising-edge detector: rise is high on the clk cycle where d goes 0->1.
module edge_rise (
    input  logic clk,
    input  logic clr_n,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) d_q <= 1'b0;
        else        d_q <= d;
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/vga_sync.sv
// VGA timing generator; dclk qualifies counter advance inside the clk domain.
// VGA_SYNC_EDGE_DET_EN: treat dclk as a level and tick on its rising edge; otherwise dclk is a strobe.
module vga_sync
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_D,
    parameter int H_FP     = H_FP_D,
    parameter int H_SYNC   = H_SYNC_D,
    parameter int H_BP     = H_BP_D,
    parameter int V_ACTIVE = V_ACTIVE_D,
    parameter int V_FP     = V_FP_D,
    parameter int V_SYNC   = V_SYNC_D,
    parameter int V_BP     = V_BP_D
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       dclk,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS    = coord_t'(H_ACTIVE);
    localparam coord_t V_VIS    = coord_t'(V_ACTIVE);
    localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_timing
        $error("vga_sync: H_TOTAL/V_TOTAL must not exceed 1024");
    end

    logic pix_tick;

`ifdef VGA_SYNC_EDGE_DET_EN
    edge_rise u_edge (
        .clk  (clk),
        .clr_n(clr_n),
        .d    (dclk),
        .rise (pix_tick)
    );
`else
    assign pix_tick = dclk;
`endif

    coord_t x_nx, y_nx;
    logic   hsync_nx, vsync_nx, video_nx;

    always_comb begin
        x_nx = x + 10'd1;
        y_nx = y;
        if (x == H_LAST) begin
            x_nx = '0;
            y_nx = (y == V_LAST) ? '0 : y + 10'd1;
        end
        // Decode from the next counter values so outputs line up with the new (x, y).
        hsync_nx = !((x_nx >= HS_START) && (x_nx <= HS_END));
        vsync_nx = !((y_nx >= VS_START) && (y_nx <= VS_END));
        video_nx = (x_nx < H_VIS) && (y_nx < V_VIS);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            x           <= '0;
            y           <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (pix_tick) begin
                x           <= x_nx;
                y           <= y_nx;
                hsync       <= hsync_nx;
                vsync       <= vsync_nx;
                video_on    <= video_nx;
                line_start  <= (x_nx == '0);
                frame_start <= (x_nx == '0) && (y_nx == '0);
            end
        end
    end

endmodule

// File: tb/tb_vga_sync.sv
// Randomized check of vga_sync (small timing) against a tick-count reference model.
module tb_vga_sync;

    localparam int HA = 16, HF = 2, HS = 4, HB = 3;
    localparam int VA = 8,  VF = 1, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic       dclk = 1'b0;
    logic       hsync, vsync, video_on, line_start, frame_start;
    logic [9:0] x, y;

    vga_sync #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk), .clr_n(clr_n), .dclk(dclk),
        .hsync(hsync), .vsync(vsync), .video_on(video_on),
        .x(x), .y(y), .line_start(line_start), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state: number of ticks since reset plus last-cycle strobe info.
    longint t = 0;
    bit     started = 0;
    bit     tick_now = 0;
    bit     prev_d = 0;
    int     frames_seen = 0;
    int     frames_exp = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d (tick %0d)", tag, obs, exp, t);
        end
    endtask

    task automatic check_all();
        int ex, ey;
        ex = int'(t % HT);
        ey = int'((t / HT) % VT);
        chk("x", 32'(x), 32'(ex));
        chk("y", 32'(y), 32'(ey));
        chk("hsync", 32'(hsync), 32'(!(ex >= HA + HF && ex < HA + HF + HS)));
        chk("vsync", 32'(vsync), 32'(!(ey >= VA + VF && ey < VA + VF + VS)));
        chk("video_on", 32'(video_on), 32'(started && ex < HA && ey < VA));
        chk("line_start", 32'(line_start), 32'(tick_now && ex == 0));
        chk("frame_start", 32'(frame_start), 32'(tick_now && ex == 0 && ey == 0));
    endtask

    task automatic model_reset();
        t = 0; started = 0; tick_now = 0; prev_d = 0;
    endtask

    // Drive dclk for one clk cycle, advance the model, sample 1 time unit after the edge.
    task automatic step(input logic d);
        dclk = d;
        @(posedge clk);
        #1;
        if (clr_n) begin
`ifdef VGA_SYNC_EDGE_DET_EN
            tick_now = d && !prev_d;
`else
            tick_now = d;
`endif
            prev_d = d;
            if (tick_now) begin
                t++;
                started = 1;
                if (t % (HT * VT) == 0) frames_exp++;
            end
        end else begin
            model_reset();
        end
        if (frame_start === 1'b1) frames_seen++;
        check_all();
    endtask

    initial begin
        // Reset held while dclk toggles: nothing may move.
        clr_n = 1'b0;
        for (int i = 0; i < 8; i++) step(logic'(i[0]));

        @(posedge clk); #1;
        clr_n = 1'b1;

        // Back-to-back and sparse ticks.
        for (int i = 0; i < 60; i++) step(1'b1);
        for (int i = 0; i < 200; i++) step((i % 4) == 0);

        // Hold dclk high: freezes in level mode, free-runs as a strobe.
        step(1'b0);
        for (int i = 0; i < 100; i++) step(1'b1);
        step(1'b0);

        // Random density long enough to cover several full frames.
        for (int i = 0; i < 3000; i++) step(logic'($urandom_range(0, 1)));
        chk("frame_count", 32'(frames_seen), 32'(frames_exp));
        chk("frames_nonzero", 32'(frames_exp >= 2), 32'd1);

        // Mid-frame asynchronous reset, away from the clock edge.
        while (!(t % HT >= HT - 5 && (t / HT) % VT >= 3)) step(logic'($urandom_range(0, 1)));
        #3;
        clr_n = 1'b0;
        #1;
        model_reset();
        check_all();
        for (int i = 0; i < 4; i++) step(logic'($urandom_range(0, 1)));
        @(posedge clk); #1;
        clr_n = 1'b1;
        step(1'b0);
        step(1'b1);
        chk("first_x", 32'(x), 32'd1);
        chk("first_y", 32'(y), 32'd0);
        for (int i = 0; i < 400; i++) step(logic'($urandom_range(0, 1)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
